// File: rtl/despachante_aprovados_pkg.sv
// rtl/despachante_aprovados_pkg.sv - shared widths and state encoding for the approved-node dispatcher
// Holds the default widths shared with the active-node evaluator and the
// 3-bit dispatcher state encoding.
package despachante_aprovados_pkg;

    localparam int DEF_NUM_NA          = 4;
    localparam int DEF_ADDR_WIDTH      = 5;
    localparam int DEF_DISTANCIA_WIDTH = 5;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GRAVAR     = 3'd1,
        ST_EXPANDIR   = 3'd2,
        ST_REMOVER    = 3'd3,
        ST_ESPERA     = 3'd4,
        ST_ENCONTRADO = 3'd5
    } estado_t;

endpackage

// File: rtl/despachante_aprovados_codificador_prioridade.sv
// rtl/despachante_aprovados_codificador_prioridade.sv - lowest-set-bit priority encoder
// Ports:
//   mascara_in  : NUM_NA-bit mask
//   idx_out     : index of the lowest set bit (0 when mask is empty)
//   tem_bit_out : at least one bit of the mask is set
module codificador_prioridade
    import despachante_aprovados_pkg::*;
#(
    parameter  int NUM_NA = DEF_NUM_NA,
    localparam int IDX_W  = (NUM_NA > 1) ? $clog2(NUM_NA) : 1
) (
    input  logic [NUM_NA-1:0] mascara_in,
    output logic [IDX_W-1:0]  idx_out,
    output logic              tem_bit_out
);

    // Scan from the top down so the last hit, the lowest index, wins.
    always_comb begin
        idx_out     = '0;
        tem_bit_out = 1'b0;
        for (int i = NUM_NA - 1; i >= 0; i--) begin
            if (mascara_in[i]) begin
                idx_out     = IDX_W'(i);
                tem_bit_out = 1'b1;
            end
        end
    end

endmodule

// File: rtl/despachante_aprovados.sv
// rtl/despachante_aprovados.sv - serialises approved nodes into predecessor writes and expansion requests
// Snapshots the evaluator's approved mask and buses, then for each approved
// slot (lowest first) writes the predecessor memory, stops if the node is the
// destination, otherwise hands it to the neighbour expander (valid/ready).
// When the mask is exhausted it pulses da_remover_aprovados_out.
// Ports: clk, rst_n (async active-low), limpar_in (sync abort), destino_in,
//   aa_* evaluator inputs, exp_pronto_in (expander ready); da_* outputs for
//   evaluator pulse, predecessor memory write, expansion request, status.
// Optional macro DESPACHANTE_CONTADOR_EN adds da_num_expandidos_out, a
// saturating 16-bit count of accepted expansion handshakes.
module despachante_aprovados
    import despachante_aprovados_pkg::*;
#(
    parameter int NUM_NA          = DEF_NUM_NA,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int DISTANCIA_WIDTH = DEF_DISTANCIA_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              limpar_in,
    input  logic [ADDR_WIDTH-1:0]             destino_in,
    input  logic                              aa_pronto_in,
    input  logic                              aa_ocupado_in,
    input  logic                              aa_tem_aprovado_in,
    input  logic [NUM_NA-1:0]                 aa_aprovado_in,
    input  logic [ADDR_WIDTH*NUM_NA-1:0]      aa_endereco_in,
    input  logic [DISTANCIA_WIDTH*NUM_NA-1:0] aa_distancia_in,
    input  logic [ADDR_WIDTH*NUM_NA-1:0]      aa_anterior_data_in,
    input  logic                              exp_pronto_in,
    output logic                              da_remover_aprovados_out,
    output logic                              da_mem_we_out,
    output logic [ADDR_WIDTH-1:0]             da_mem_addr_out,
    output logic [ADDR_WIDTH-1:0]             da_mem_data_out,
    output logic                              da_exp_valid_out,
    output logic [ADDR_WIDTH-1:0]             da_exp_endereco_out,
    output logic [DISTANCIA_WIDTH-1:0]        da_exp_distancia_out,
    output logic                              da_encontrado_out,
`ifdef DESPACHANTE_CONTADOR_EN
    output logic [15:0]                       da_num_expandidos_out,
`endif
    output logic                              da_ocupado_out
);

    localparam int IDX_W = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;

    estado_t                              estado_q, estado_d;
    logic [NUM_NA-1:0]                    mascara_q, mascara_d;
    logic [ADDR_WIDTH*NUM_NA-1:0]         endereco_q, endereco_d;
    logic [ADDR_WIDTH*NUM_NA-1:0]         anterior_q, anterior_d;
    logic [DISTANCIA_WIDTH*NUM_NA-1:0]    distancia_q, distancia_d;

    logic [IDX_W-1:0]                     idx;
    logic                                 tem_bit;
    logic [ADDR_WIDTH-1:0]                endereco_sel;
    logic [ADDR_WIDTH-1:0]                anterior_sel;
    logic [DISTANCIA_WIDTH-1:0]           distancia_sel;
    logic [NUM_NA-1:0]                    mascara_restante;
    logic                                 handshake;

    codificador_prioridade #(.NUM_NA(NUM_NA)) u_codificador (
        .mascara_in  (mascara_q),
        .idx_out     (idx),
        .tem_bit_out (tem_bit)
    );

    assign endereco_sel     = endereco_q[ADDR_WIDTH*idx +: ADDR_WIDTH];
    assign anterior_sel     = anterior_q[ADDR_WIDTH*idx +: ADDR_WIDTH];
    assign distancia_sel    = distancia_q[DISTANCIA_WIDTH*idx +: DISTANCIA_WIDTH];
    assign mascara_restante = mascara_q & ~(NUM_NA'(1) << idx);
    assign handshake        = (estado_q == ST_EXPANDIR) && exp_pronto_in;

    // State and snapshot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= ST_IDLE;
            mascara_q   <= '0;
            endereco_q  <= '0;
            anterior_q  <= '0;
            distancia_q <= '0;
        end else begin
            estado_q    <= estado_d;
            mascara_q   <= mascara_d;
            endereco_q  <= endereco_d;
            anterior_q  <= anterior_d;
            distancia_q <= distancia_d;
        end
    end

    // Next state and snapshot update
    always_comb begin
        estado_d    = estado_q;
        mascara_d   = mascara_q;
        endereco_d  = endereco_q;
        anterior_d  = anterior_q;
        distancia_d = distancia_q;
        case (estado_q)
            ST_IDLE: begin
                if (aa_pronto_in && aa_tem_aprovado_in && !aa_ocupado_in) begin
                    mascara_d   = aa_aprovado_in;
                    endereco_d  = aa_endereco_in;
                    anterior_d  = aa_anterior_data_in;
                    distancia_d = aa_distancia_in;
                    estado_d    = ST_GRAVAR;
                end
            end
            ST_GRAVAR: begin
                if (!tem_bit) begin
                    estado_d = ST_REMOVER;
                end else if (endereco_sel == destino_in) begin
                    estado_d = ST_ENCONTRADO;
                end else begin
                    estado_d = ST_EXPANDIR;
                end
            end
            ST_EXPANDIR: begin
                if (exp_pronto_in) begin
                    mascara_d = mascara_restante;
                    estado_d  = (|mascara_restante) ? ST_GRAVAR : ST_REMOVER;
                end
            end
            ST_REMOVER:    estado_d = ST_ESPERA;
            // Gives the evaluator a cycle to drop its registered approvals.
            ST_ESPERA:     estado_d = ST_IDLE;
            ST_ENCONTRADO: estado_d = ST_ENCONTRADO;
            default:       estado_d = ST_IDLE;
        endcase
        // Abort wins over everything, including an in-flight handshake.
        if (limpar_in) begin
            estado_d    = ST_IDLE;
            mascara_d   = '0;
            endereco_d  = '0;
            anterior_d  = '0;
            distancia_d = '0;
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        da_remover_aprovados_out = 1'b0;
        da_mem_we_out            = 1'b0;
        da_mem_addr_out          = '0;
        da_mem_data_out          = '0;
        da_exp_valid_out         = 1'b0;
        da_exp_endereco_out      = '0;
        da_exp_distancia_out     = '0;
        da_encontrado_out        = 1'b0;
        da_ocupado_out           = (estado_q != ST_IDLE) && (estado_q != ST_ENCONTRADO);
        case (estado_q)
            ST_GRAVAR: begin
                da_mem_we_out   = tem_bit;
                da_mem_addr_out = endereco_sel;
                da_mem_data_out = anterior_sel;
            end
            ST_EXPANDIR: begin
                da_exp_valid_out     = 1'b1;
                da_exp_endereco_out  = endereco_sel;
                da_exp_distancia_out = distancia_sel;
            end
            ST_REMOVER:    da_remover_aprovados_out = 1'b1;
            ST_ENCONTRADO: da_encontrado_out        = 1'b1;
            default: ;
        endcase
    end

`ifdef DESPACHANTE_CONTADOR_EN
    logic [15:0] contador_q, contador_d;

    always_comb begin
        contador_d = contador_q;
        if (limpar_in) begin
            contador_d = '0;
        end else if (handshake && (contador_q != 16'hFFFF)) begin
            contador_d = contador_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contador_q <= '0;
        end else begin
            contador_q <= contador_d;
        end
    end

    assign da_num_expandidos_out = contador_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_despachante_aprovados.sv
// tb/tb_despachante_aprovados.sv - scoreboard bench for despachante_aprovados
module tb_despachante_aprovados;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 5;

    localparam int K_WR  = 0;
    localparam int K_EXP = 1;
    localparam int K_REM = 2;
    localparam int K_ENC = 3;

    typedef struct {
        int kind;
        int a;
        int b;
        int cyc;
    } ev_t;

    logic            clk;
    logic            rst_n;
    logic            limpar;
    logic [AW-1:0]   destino;
    logic            pronto;
    logic            ocupado;
    logic            tem;
    logic [N-1:0]    aprovado;
    logic [AW*N-1:0] endereco;
    logic [DW*N-1:0] distancia;
    logic [AW*N-1:0] anterior;
    logic            exp_pronto;
    logic            remover;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [AW-1:0]   mem_data;
    logic            exp_valid;
    logic [AW-1:0]   exp_endereco;
    logic [DW-1:0]   exp_distancia;
    logic            encontrado;
    logic            ocupado_out;
`ifdef DESPACHANTE_CONTADOR_EN
    logic [15:0]     num_exp;
`endif

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic enc_prev = 1'b0;
    ev_t  fila[$];
    int   end_m[N];
    int   ant_m[N];
    int   dist_m[N];

    despachante_aprovados dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .limpar_in                (limpar),
        .destino_in               (destino),
        .aa_pronto_in             (pronto),
        .aa_ocupado_in            (ocupado),
        .aa_tem_aprovado_in       (tem),
        .aa_aprovado_in           (aprovado),
        .aa_endereco_in           (endereco),
        .aa_distancia_in          (distancia),
        .aa_anterior_data_in      (anterior),
        .exp_pronto_in            (exp_pronto),
        .da_remover_aprovados_out (remover),
        .da_mem_we_out            (mem_we),
        .da_mem_addr_out          (mem_addr),
        .da_mem_data_out          (mem_data),
        .da_exp_valid_out         (exp_valid),
        .da_exp_endereco_out      (exp_endereco),
        .da_exp_distancia_out     (exp_distancia),
        .da_encontrado_out        (encontrado),
`ifdef DESPACHANTE_CONTADOR_EN
        .da_num_expandidos_out    (num_exp),
`endif
        .da_ocupado_out           (ocupado_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic got(input int k, input int a, input int b);
        ev_t e;
        vectors++;
        if (fila.size() == 0) begin
            miscompares++;
            $display("FAIL monitor: got unexpected kind=%0d a=%0d b=%0d cyc=%0d, expected no event", k, a, b, cyc);
        end else begin
            e = fila.pop_front();
            if (e.kind != k || e.a != a || e.b != b || e.cyc != cyc) begin
                miscompares++;
                $display("FAIL monitor: got kind=%0d a=%0d b=%0d cyc=%0d, expected kind=%0d a=%0d b=%0d cyc=%0d",
                         k, a, b, cyc, e.kind, e.a, e.b, e.cyc);
            end
        end
    endtask

    // Monitor: every observable event is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we)               got(K_WR, int'(mem_addr), int'(mem_data));
            if (exp_valid && exp_pronto) got(K_EXP, int'(exp_endereco), int'(exp_distancia));
            if (remover)              got(K_REM, 0, 0);
            if (encontrado && !enc_prev) got(K_ENC, 0, 0);
        end
        enc_prev <= encontrado;
    end

    task automatic push(input int k, input int a, input int b, input int c);
        ev_t e;
        e.kind = k; e.a = a; e.b = b; e.cyc = c;
        fila.push_back(e);
    endtask

    // Expected sequence for a capture in cycle c with ready held high:
    // write at c+1+2n, expansion at c+2+2n, remover after the last entry.
    task automatic push_seq(input logic [N-1:0] mask, input int c);
        int n;
        n = 0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                push(K_WR, end_m[i], ant_m[i], c + 1 + 2*n);
                push(K_EXP, end_m[i], dist_m[i], c + 2 + 2*n);
                n++;
            end
        end
        push(K_REM, 0, 0, c + 1 + 2*n);
    endtask

    task automatic set_slot(input int i, input int a, input int p, input int d);
        end_m[i]  = a;
        ant_m[i]  = p;
        dist_m[i] = d;
        endereco[AW*i +: AW]  = AW'(a);
        anterior[AW*i +: AW]  = AW'(p);
        distancia[DW*i +: DW] = DW'(d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_n = 1'b0; limpar = 1'b0; destino = 5'd31; pronto = 1'b0; ocupado = 1'b0;
        tem = 1'b0; aprovado = '0; endereco = '0; distancia = '0; anterior = '0;
        exp_pronto = 1'b1;
        for (int i = 0; i < N; i++) set_slot(i, 0, 0, 0);
        tick(); tick();
        check("reset_outputs", int'({remover, mem_we, mem_addr, mem_data, exp_valid,
                                     exp_endereco, exp_distancia, encontrado, ocupado_out}), 0);
        rst_n = 1'b1;
        tick();

        // Two entries, ready high; evaluator changes after capture are ignored.
        set_slot(1, 3, 1, 4); set_slot(3, 7, 2, 6);
        aprovado = 4'b1010; tem = 1'b1; pronto = 1'b1;
        c = cyc;
        push_seq(4'b1010, c);
        tick();
        pronto = 1'b0; tem = 1'b0; aprovado = 4'b1111;
        set_slot(1, 0, 0, 0); set_slot(3, 0, 0, 0);
        wait_until(c + 6);
        check("t1_ocupado_espera", int'(ocupado_out), 1);
        tick();
        check("t1_idle_c7", int'(ocupado_out), 0);

        // Destination hit on a single entry.
        set_slot(0, 9, 5, 2); destino = 5'd9;
        aprovado = 4'b0001; tem = 1'b1; pronto = 1'b1;
        c = cyc;
        push(K_WR, 9, 5, c + 1);
        push(K_ENC, 0, 0, c + 2);
        wait_until(c + 2);
        check("t2_encontrado", int'(encontrado), 1);
        check("t2_ocupado", int'(ocupado_out), 0);
        wait_until(c + 6);
        check("t2_encontrado_held", int'(encontrado), 1);
        check("t2_no_valid", int'(exp_valid), 0);
        pronto = 1'b0; tem = 1'b0;
        limpar = 1'b1;
        tick();
        limpar = 1'b0;
        check("t2_limpar_encontrado", int'(encontrado), 0);
        check("t2_limpar_ocupado", int'(ocupado_out), 0);
        destino = 5'd31;
        tick();

        // Backpressure: ready low for 5 EXPANDIR cycles.
        set_slot(2, 12, 4, 10);
        aprovado = 4'b0100; tem = 1'b1; pronto = 1'b1; exp_pronto = 1'b0;
        c = cyc;
        push(K_WR, 12, 4, c + 1);
        tick();
        pronto = 1'b0; tem = 1'b0;
        wait_until(c + 2);
        for (int k = 0; k < 5; k++) begin
            check("t3_valid_held", int'(exp_valid), 1);
            check("t3_addr_held", int'(exp_endereco), 12);
            check("t3_dist_held", int'(exp_distancia), 10);
            tick();
        end
        push(K_EXP, 12, 10, c + 7);
        push(K_REM, 0, 0, c + 8);
        exp_pronto = 1'b1;
        wait_until(c + 8);
        check("t3_ocupado_remover", int'(ocupado_out), 1);
        wait_until(c + 10);
        check("t3_idle", int'(ocupado_out), 0);

        // Evaluator busy blocks capture until it drops.
        set_slot(0, 20, 3, 1);
        aprovado = 4'b0001; tem = 1'b1; pronto = 1'b1; ocupado = 1'b1;
        c = cyc;
        wait_until(c + 2);
        check("t4_no_capture", int'(ocupado_out), 0);
        wait_until(c + 3);
        ocupado = 1'b0;
        push_seq(4'b0001, c + 3);
        tick();
        pronto = 1'b0; tem = 1'b0;
        wait_until(c + 9);

        // Async reset in EXPANDIR, then full-mask recapture.
        set_slot(0, 1, 10, 5); set_slot(1, 2, 11, 6); set_slot(2, 3, 12, 7); set_slot(3, 4, 13, 8);
        aprovado = 4'b1111; tem = 1'b1; pronto = 1'b1; exp_pronto = 1'b0;
        c = cyc;
        push(K_WR, 1, 10, c + 1);
        tick();
        pronto = 1'b0; tem = 1'b0;
        wait_until(c + 2);
        check("t5_valid_before_reset", int'(exp_valid), 1);
        rst_n = 1'b0;
        #1;
        check("t5_reset_valid", int'(exp_valid), 0);
        check("t5_reset_addr", int'(exp_endereco), 0);
        check("t5_reset_ocupado", int'(ocupado_out), 0);
        check("t5_reset_we", int'(mem_we), 0);
        tick();
        rst_n = 1'b1; exp_pronto = 1'b1;
        tick();
        tem = 1'b1; pronto = 1'b1;
        c = cyc;
        push_seq(4'b1111, c);
        tick();
        pronto = 1'b0; tem = 1'b0;
        wait_until(c + 11);
        check("t5_idle_after_full", int'(ocupado_out), 0);

`ifdef DESPACHANTE_CONTADOR_EN
        limpar = 1'b1;
        tick();
        limpar = 1'b0;
        check("t6_cont_zero", int'(num_exp), 0);
        for (int r = 0; r < 2; r++) begin
            set_slot(0, 1 + r, 2, 3); set_slot(1, 4, 5, 6); set_slot(2, 7, 8, 9);
            aprovado = 4'b0111; tem = 1'b1; pronto = 1'b1;
            c = cyc;
            push_seq(4'b0111, c);
            tick();
            pronto = 1'b0; tem = 1'b0;
            wait_until(c + 10);
        end
        check("t6_cont_six", int'(num_exp), 6);
        limpar = 1'b1;
        tick();
        limpar = 1'b0;
        check("t6_cont_cleared", int'(num_exp), 0);
`endif

        tick(); tick(); tick();
        check("fila_vazia", fila.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/despachante_aprovados.md
Name: despachante_aprovados

Overview:
- Downstream stage of the active-node evaluator. Consumes its approved-node vector, address, distance and predecessor buses.
- Serialises approved entries, lowest index first. For each entry it writes the predecessor memory, checks it against the destination, and hands non-destination nodes to the neighbour expander through a valid/ready handshake.
- When all entries are done it pulses remover_aprovados back to the evaluator.

Parameters:
- NUM_NA, 4, number of active-node slots (matches evaluator).
- ADDR_WIDTH, 5, node address width.
- DISTANCIA_WIDTH, 5, accumulated distance width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- limpar_in  in  1  synchronous abort/restart; returns to IDLE, clears sticky flags
- destino_in  in  ADDR_WIDTH  destination node address
- aa_pronto_in  in  1  evaluator classification settled
- aa_ocupado_in  in  1  evaluator busy
- aa_tem_aprovado_in  in  1  any approved slot
- aa_aprovado_in  in  NUM_NA  approved mask
- aa_endereco_in  in  ADDR_WIDTH*NUM_NA  slot addresses, slot i at [ADDR_WIDTH*i +: ADDR_WIDTH]
- aa_distancia_in  in  DISTANCIA_WIDTH*NUM_NA  slot distances, same packing
- aa_anterior_data_in  in  ADDR_WIDTH*NUM_NA  slot predecessors, same packing
- exp_pronto_in  in  1  expander ready
- da_remover_aprovados_out  out  1  one-cycle pulse to evaluator
- da_mem_we_out  out  1  predecessor memory write enable
- da_mem_addr_out  out  ADDR_WIDTH  write address (node)
- da_mem_data_out  out  ADDR_WIDTH  write data (predecessor)
- da_exp_valid_out  out  1  expansion request valid
- da_exp_endereco_out  out  ADDR_WIDTH  node to expand
- da_exp_distancia_out  out  DISTANCIA_WIDTH  its distance
- da_encontrado_out  out  1  sticky: destination reached
- da_ocupado_out  out  1  high in any state except IDLE and ENCONTRADO

Behaviour:
- Reset: all outputs 0; state IDLE; snapshot registers 0.
- IDLE: capture when aa_pronto_in && aa_tem_aprovado_in && !aa_ocupado_in.
  - On capture, register the mask and all three buses (snapshot) and go to GRAVAR next cycle.
  - Evaluator changes after capture are ignored.
- GRAVAR: idx = lowest set bit of the snapshot mask (combinational priority encode).
  - da_mem_we_out=1 for exactly one cycle, with addr=endereco[idx] and data=anterior[idx].
  - Next state is ENCONTRADO if endereco[idx]==destino_in, else EXPANDIR.
- EXPANDIR: valid=1, with endereco/distancia of idx held stable until exp_pronto_in is sampled high.
  - On that handshake, clear mask bit idx.
  - Next state is GRAVAR if any bit remains, else REMOVER.
  - Valid may be high in the same cycle ready rises; the transfer completes that cycle.
- REMOVER: da_remover_aprovados_out=1 for one cycle, then ESPERA.
- ESPERA: one cycle so the registered approved flags in the evaluator clear, then IDLE. This prevents re-capturing stale approvals.
- ENCONTRADO: da_encontrado_out=1 and held.
  - No remover pulse, no further expansion.
  - Exit only via limpar_in or reset.
- Latency:
  - capture cycle c, memory write at c+1, earliest valid at c+2.
  - Each entry costs at least 2 cycles.
  - Full mask of 4 with ready tied high: remover pulse at c+9.
- limpar_in: highest priority over every transition.
  - Forces IDLE and clears snapshot, valid, encontrado and remover in the next cycle.
  - An in-flight request is dropped, not completed.
- Mask with a single bit behaves the same as a full mask; there are no zero-entry states.
- Async reset mid-operation: immediate return to the reset values above.

Optional Feature:
- DESPACHANTE_CONTADOR_EN
- Defined:
  - adds output da_num_expandidos_out, 16 bits, reset 0.
  - Incremented on each accepted expansion handshake; saturates at 16'hFFFF; cleared by limpar_in.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package/include holds:
  - state encodings (IDLE, GRAVAR, EXPANDIR, REMOVER, ESPERA, ENCONTRADO; 3-bit);
  - default widths shared with the evaluator (NUM_NA, ADDR_WIDTH, DISTANCIA_WIDTH).
- One natural sub-module: codificador_prioridade, parameterised NUM_NA.
  - Outputs the lowest-set-bit index, $clog2(NUM_NA) bits, plus a tem_bit flag.

Test Plan:
- Mask 4'b1010, addresses 3 and 7, predecessors 1 and 2, destino 31, ready=1. Expect: memory writes (3,1) at c+1 and (7,2) at c+3; expansions of 3 then 7; remover pulse at c+5; IDLE at c+7.
- Mask 4'b0001, address 9 == destino 9. Expect: memory write (9, predecessor) at c+1, encontrado high from c+2 and held; valid and remover never assert; limpar_in returns to IDLE with encontrado 0.
- Backpressure: hold exp_pronto_in low for 5 cycles during EXPANDIR. Expect: valid, address and distance stable for all 5 cycles; bit cleared only on the ready cycle; no second memory write.
- aa_ocupado_in=1 while aa_pronto_in=1 and aa_tem_aprovado_in=1. Expect: no capture; capture the cycle after ocupado drops.
- Assert rst_n low during EXPANDIR with mask 4'b1111. Expect: all outputs 0 immediately; after release, a recapture processes slot 0 first.
- With DESPACHANTE_CONTADOR_EN defined: two captures of 3 approvals each. Expect: counter reads 6; after limpar_in it reads 0.
